// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-bus CPU control path.
//   - Opcode encodings (IR[31:27]).
//   - Sequencer step enum (RST, T0..T7, HALT).
//   - Instruction class enum produced by instr_class_decode.
//   - Packed bundle of every DataPath control strobe, in port order.
package cpu_defs_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } step_t;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFLO, C_MFHI, C_NOP, C_HALT
    } iclass_t;

    // Field order matches the control_unit strobe ports, so the whole
    // bundle can be unpacked onto the ports with one concatenation.
    typedef struct packed {
        logic gra, grb, grc, rin, rout, ba_out;
        logic hi_in, hi_out, lo_in, lo_out;
        logic z_in, z_high_out, z_low_out, y_in, c_out;
        logic mdr_in, mdr_out, mar_in, pc_in, pc_out, ir_in, inc_pc;
        logic read, write;
        logic con_in, in_port_out, out_port_in;
    } strobes_t;

endpackage

// File: rtl/instr_class_decode.sv
// Opcode -> instruction class. Purely combinational.
//   op     : IR[31:27]
//   iclass : execute-sequence class; undefined opcodes map to C_NOP.
module instr_class_decode
    import cpu_defs_pkg::*;
(
    input  logic [4:0] op,
    output iclass_t    iclass
);

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        iclass = C_NOP;
        case (op) inside
            [OP_ADD:OP_SHL]:   iclass = C_ALU3;
            [OP_ADDI:OP_ORI]:  iclass = C_IMM;
            OP_NEG, OP_NOT:    iclass = C_UNARY;
            OP_MUL, OP_DIV:    iclass = C_MULDIV;
            OP_LD:             iclass = C_LD;
            OP_LDI:            iclass = C_LDI;
            OP_ST:             iclass = C_ST;
            OP_BR:             iclass = C_BR;
            OP_JR:             iclass = C_JR;
            OP_JAL:            iclass = C_JAL;
            OP_IN:             iclass = C_IN;
            OP_OUT:            iclass = C_OUT;
            OP_MFLO:           iclass = C_MFLO;
            OP_MFHI:           iclass = C_MFHI;
            OP_HALT:           iclass = C_HALT;
            default:           iclass = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the single-bus DataPath.
//   clock, clear   : clock and synchronous active-low reset
//   ir             : instruction register; only the opcode field is used
//   con            : branch condition flip-flop
//   mem_ready      : memory finished the pending read/write this cycle
//   strobe outputs : one-cycle DataPath enables decoded from the step
//   opcode         : ALU operation for the current step
//   run            : 0 only while halted
// Execute steps read the class from ir directly; the DataPath latches
// IR at the end of T2, so ir is stable for all of T3..T7.
module control_unit
    import cpu_defs_pkg::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [IRW-1:0] ir,
    input  logic           con,
    input  logic           mem_ready,
    output logic           Gra, Grb, Grc, Rin, Rout, BAout,
    output logic           HIin, HIout, LOin, LOout,
    output logic           Zin, Zhighout, Zlowout, Yin, Cout,
    output logic           MDRin, MDRout, MARin, PCin, PCout, IRin, IncPC,
    output logic           read, write,
    output logic           CONin, InPortout, OutPortin,
    output logic [OPW-1:0] opcode,
    output logic           run
);

    step_t          state;
    iclass_t        iclass;
    strobes_t       s;
    logic [OPW-1:0] op;
    logic           unused_ir_bits;

    assign op             = ir[IRW-1 -: OPW];
    assign unused_ir_bits = ^ir[IRW-OPW-1:0];

    instr_class_decode u_decode (
        .op     (op),
        .iclass (iclass)
    );

    // Step sequencing. clear wins over every step, including stalls and HALT.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!clear) begin
            state <= RST;
        end else begin
            case (state)
                RST: state <= T0;
                T0:  state <= T1;
                T1:  if (mem_ready) state <= T2;
                T2:  state <= T3;
                T3: begin
                    case (iclass)
                        C_HALT:                       state <= HALT;
                        C_JR, C_IN, C_OUT, C_MFLO,
                        C_MFHI, C_NOP:                state <= T0;
                        default:                      state <= T4;
                    endcase
                end
                T4:  state <= (iclass == C_UNARY || iclass == C_JAL) ? T0 : T5;
                T5: begin
                    case (iclass)
                        C_ALU3, C_IMM, C_LDI: state <= T0;
                        default:              state <= T6;
                    endcase
                end
                T6: begin
                    case (iclass)
                        C_LD:    if (mem_ready) state <= T7;
                        C_ST:    state <= T7;
                        default: state <= T0;
                    endcase
                end
                T7:   if (iclass != C_ST || mem_ready) state <= T0;
                HALT: state <= HALT;
                default: state <= RST;
            endcase
        end
    end

    // Moore output decode: strobes depend on step and class only
    // (plus con for the conditional PC load in the branch T6).
    always_comb begin
        s      = '0;
        opcode = '0;
        run    = 1'b1;
        case (state)
            T0: {s.pc_out, s.mar_in, s.inc_pc, s.z_in} = '1;
            T1: {s.z_low_out, s.pc_in, s.read, s.mdr_in} = '1;
            T2: {s.mdr_out, s.ir_in} = '1;
            T3: begin
                case (iclass)
                    C_ALU3, C_IMM:     {s.grb, s.rout, s.y_in} = '1;
                    C_UNARY: begin
                        {s.grb, s.rout, s.z_in} = '1;
                        opcode = op;
                    end
                    C_MULDIV:          {s.gra, s.rout, s.y_in} = '1;
                    C_LD, C_LDI, C_ST: {s.grb, s.ba_out, s.y_in} = '1;
                    C_BR:              {s.gra, s.rout, s.con_in} = '1;
                    C_JR:              {s.gra, s.rout, s.pc_in} = '1;
                    C_JAL:             {s.pc_out, s.grb, s.rin} = '1;
                    C_IN:              {s.in_port_out, s.gra, s.rin} = '1;
                    C_OUT:             {s.gra, s.rout, s.out_port_in} = '1;
                    C_MFLO:            {s.lo_out, s.gra, s.rin} = '1;
                    C_MFHI:            {s.hi_out, s.gra, s.rin} = '1;
                    default: ;
                endcase
            end
            T4: begin
                case (iclass)
                    C_ALU3: begin
                        {s.grc, s.rout, s.z_in} = '1;
                        opcode = op;
                    end
                    C_IMM: begin
                        {s.c_out, s.z_in} = '1;
                        opcode = op;
                    end
                    C_UNARY:  {s.z_low_out, s.gra, s.rin} = '1;
                    C_MULDIV: begin
                        {s.grb, s.rout, s.z_in} = '1;
                        opcode = op;
                    end
                    C_LD, C_LDI, C_ST: begin
                        {s.c_out, s.z_in} = '1;
                        opcode = OPW'(OP_ADD);
                    end
                    C_BR:     {s.pc_out, s.y_in} = '1;
                    C_JAL:    {s.gra, s.rout, s.pc_in} = '1;
                    default: ;
                endcase
            end
            T5: begin
                case (iclass)
                    C_ALU3, C_IMM, C_LDI: {s.z_low_out, s.gra, s.rin} = '1;
                    C_MULDIV:             {s.z_low_out, s.lo_in} = '1;
                    C_LD, C_ST:           {s.z_low_out, s.mar_in} = '1;
                    C_BR: begin
                        {s.c_out, s.z_in} = '1;
                        opcode = OPW'(OP_ADD);
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (iclass)
                    C_MULDIV: {s.z_high_out, s.hi_in} = '1;
                    C_LD:     {s.read, s.mdr_in} = '1;
                    C_ST:     {s.gra, s.rout, s.mdr_in} = '1;
                    C_BR: begin
                        s.z_low_out = 1'b1;
                        s.pc_in     = con;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (iclass)
                    C_LD:    {s.mdr_out, s.gra, s.rin} = '1;
                    C_ST:    s.write = 1'b1;
                    default: ;
                endcase
            end
            HALT: run = 1'b0;
            default: ;
        endcase
    end

    assign {Gra, Grb, Grc, Rin, Rout, BAout,
            HIin, HIout, LOin, LOout,
            Zin, Zhighout, Zlowout, Yin, Cout,
            MDRin, MDRout, MARin, PCin, PCout, IRin, IncPC,
            read, write,
            CONin, InPortout, OutPortin} = s;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: decoder cross-check, a directed
// per-instruction table, hand-written multi-cycle sequences and a random
// instruction stream checked cycle by cycle against a step-list model.
module tb_control_unit;
    import cpu_defs_pkg::*;

    logic        clock = 1'b0;
    logic        clear, con, mem_ready;
    logic [31:0] ir;
    logic Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout;
    logic Zin, Zhighout, Zlowout, Yin, Cout, MDRin, MDRout, MARin, PCin, PCout;
    logic IRin, IncPC, read, write, CONin, InPortout, OutPortin, run;
    logic [4:0]  opcode;
    logic [4:0]  dec_op;
    iclass_t     ref_cls;

    control_unit #(.OPW(5), .IRW(32)) dut (
        .clock(clock), .clear(clear), .ir(ir), .con(con), .mem_ready(mem_ready),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin), .Cout(Cout),
        .MDRin(MDRin), .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .PCout(PCout),
        .IRin(IRin), .IncPC(IncPC), .read(read), .write(write),
        .CONin(CONin), .InPortout(InPortout), .OutPortin(OutPortin),
        .opcode(opcode), .run(run)
    );

    instr_class_decode u_ref (.op(dec_op), .iclass(ref_cls));

    always #5 clock = ~clock;

    localparam logic [26:0] GRA = 27'd1 << 26, GRB = 27'd1 << 25, GRC = 27'd1 << 24;
    localparam logic [26:0] RIN = 27'd1 << 23, ROUT = 27'd1 << 22, BAOUT = 27'd1 << 21;
    localparam logic [26:0] HIIN = 27'd1 << 20, HIOUT = 27'd1 << 19;
    localparam logic [26:0] LOIN = 27'd1 << 18, LOOUT = 27'd1 << 17;
    localparam logic [26:0] ZIN = 27'd1 << 16, ZHI = 27'd1 << 15, ZLO = 27'd1 << 14;
    localparam logic [26:0] YIN = 27'd1 << 13, COUT = 27'd1 << 12;
    localparam logic [26:0] MDRIN = 27'd1 << 11, MDROUT = 27'd1 << 10, MARIN = 27'd1 << 9;
    localparam logic [26:0] PCIN = 27'd1 << 8, PCOUT = 27'd1 << 7, IRIN = 27'd1 << 6;
    localparam logic [26:0] INCPC = 27'd1 << 5, READ = 27'd1 << 4, WRITE = 27'd1 << 3;
    localparam logic [26:0] CONIN = 27'd1 << 2, INPORT = 27'd1 << 1, OUTPORT = 27'd1;

    logic [26:0] act_strobes;
    assign act_strobes = {Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout,
                          Zin, Zhighout, Zlowout, Yin, Cout, MDRin, MDRout, MARin,
                          PCin, PCout, IRin, IncPC, read, write, CONin, InPortout, OutPortin};

    // One expected cycle-step of an instruction.
    typedef struct {
        logic [26:0] mask;
        logic [4:0]  opc;
        bit          stall;      // repeats while mem_ready=0
        bit          pc_if_con;  // PCin added when con=1
        bit          halt_after; // machine halts after this step
    } exp_step_t;

    typedef struct {
        logic [4:0]  op;
        bit          c;
        int          cycles;
        logic [26:0] last;
    } vec_t;

    exp_step_t   q[$];
    bit          halted;
    logic [26:0] last_obs;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_step_t mk(logic [26:0] m, logic [4:0] o, bit st, bit pc, bit h);
        exp_step_t e;
        e.mask = m; e.opc = o; e.stall = st; e.pc_if_con = pc; e.halt_after = h;
        return e;
    endfunction

    // Step list for one instruction, written straight from the per-class tables.
    function automatic void push_instr(logic [4:0] op);
        q.push_back(mk(PCOUT | MARIN | INCPC | ZIN, 5'd0, 0, 0, 0));
        q.push_back(mk(ZLO | PCIN | READ | MDRIN, 5'd0, 1, 0, 0));
        q.push_back(mk(MDROUT | IRIN, 5'd0, 0, 0, 0));
        if (op >= 3 && op <= 11) begin
            q.push_back(mk(GRB | ROUT | YIN, 5'd0, 0, 0, 0));
            q.push_back(mk(GRC | ROUT | ZIN, op, 0, 0, 0));
            q.push_back(mk(ZLO | GRA | RIN, 5'd0, 0, 0, 0));
        end else if (op >= 12 && op <= 14) begin
            q.push_back(mk(GRB | ROUT | YIN, 5'd0, 0, 0, 0));
            q.push_back(mk(COUT | ZIN, op, 0, 0, 0));
            q.push_back(mk(ZLO | GRA | RIN, 5'd0, 0, 0, 0));
        end else if (op == 17 || op == 18) begin
            q.push_back(mk(GRB | ROUT | ZIN, op, 0, 0, 0));
            q.push_back(mk(ZLO | GRA | RIN, 5'd0, 0, 0, 0));
        end else if (op == 15 || op == 16) begin
            q.push_back(mk(GRA | ROUT | YIN, 5'd0, 0, 0, 0));
            q.push_back(mk(GRB | ROUT | ZIN, op, 0, 0, 0));
            q.push_back(mk(ZLO | LOIN, 5'd0, 0, 0, 0));
            q.push_back(mk(ZHI | HIIN, 5'd0, 0, 0, 0));
        end else if (op <= 2) begin
            q.push_back(mk(GRB | BAOUT | YIN, 5'd0, 0, 0, 0));
            q.push_back(mk(COUT | ZIN, 5'd3, 0, 0, 0));
            if (op == 1) begin
                q.push_back(mk(ZLO | GRA | RIN, 5'd0, 0, 0, 0));
            end else begin
                q.push_back(mk(ZLO | MARIN, 5'd0, 0, 0, 0));
                if (op == 0) begin
                    q.push_back(mk(READ | MDRIN, 5'd0, 1, 0, 0));
                    q.push_back(mk(MDROUT | GRA | RIN, 5'd0, 0, 0, 0));
                end else begin
                    q.push_back(mk(GRA | ROUT | MDRIN, 5'd0, 0, 0, 0));
                    q.push_back(mk(WRITE, 5'd0, 1, 0, 0));
                end
            end
        end else if (op == 19) begin
            q.push_back(mk(GRA | ROUT | CONIN, 5'd0, 0, 0, 0));
            q.push_back(mk(PCOUT | YIN, 5'd0, 0, 0, 0));
            q.push_back(mk(COUT | ZIN, 5'd3, 0, 0, 0));
            q.push_back(mk(ZLO, 5'd0, 0, 1, 0));
        end else if (op == 20) begin
            q.push_back(mk(PCOUT | GRB | RIN, 5'd0, 0, 0, 0));
            q.push_back(mk(GRA | ROUT | PCIN, 5'd0, 0, 0, 0));
        end
        else if (op == 21) q.push_back(mk(GRA | ROUT | PCIN, 5'd0, 0, 0, 0));
        else if (op == 22) q.push_back(mk(INPORT | GRA | RIN, 5'd0, 0, 0, 0));
        else if (op == 23) q.push_back(mk(GRA | ROUT | OUTPORT, 5'd0, 0, 0, 0));
        else if (op == 24) q.push_back(mk(LOOUT | GRA | RIN, 5'd0, 0, 0, 0));
        else if (op == 25) q.push_back(mk(HIOUT | GRA | RIN, 5'd0, 0, 0, 0));
        else if (op == 27) q.push_back(mk(27'd0, 5'd0, 0, 0, 1));
        else               q.push_back(mk(27'd0, 5'd0, 0, 0, 0));
    endfunction

    function automatic iclass_t ref_class(logic [4:0] op);
        if (op >= 3 && op <= 11)   return C_ALU3;
        if (op >= 12 && op <= 14)  return C_IMM;
        if (op == 15 || op == 16)  return C_MULDIV;
        if (op == 17 || op == 18)  return C_UNARY;
        case (op)
            5'd0:  return C_LD;
            5'd1:  return C_LDI;
            5'd2:  return C_ST;
            5'd19: return C_BR;
            5'd20: return C_JAL;
            5'd21: return C_JR;
            5'd22: return C_IN;
            5'd23: return C_OUT;
            5'd24: return C_MFLO;
            5'd25: return C_MFHI;
            5'd27: return C_HALT;
            default: return C_NOP;
        endcase
    endfunction

    // Called at posedge+1: drive inputs, compare at negedge, advance model.
    task automatic do_cycle(input bit rdy, input bit c, input string tag);
        logic [32:0] exp;
        exp_step_t   st;
        mem_ready = rdy;
        con       = c;
        @(negedge clock);
        if (halted || q.size() == 0) begin
            exp = {27'd0, 5'd0, 1'b0};
        end else begin
            st  = q[0];
            exp = {st.mask | ((st.pc_if_con && c) ? PCIN : 27'd0), st.opc, 1'b1};
        end
        check(tag, 64'({act_strobes, opcode, run}), 64'(exp));
        last_obs = act_strobes;
        if (!halted && q.size() > 0) begin
            if (!(q[0].stall && !rdy)) begin
                if (q[0].halt_after) halted = 1'b1;
                void'(q.pop_front());
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        clear = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            check("reset_rst", 64'({act_strobes, opcode, run}), 64'({27'd0, 5'd0, 1'b1}));
        end
        @(posedge clock); #1;
        clear = 1'b1;
        @(negedge clock);
        check("reset_hold", 64'({act_strobes, opcode, run}), 64'({27'd0, 5'd0, 1'b1}));
        @(posedge clock); #1;
        q.delete();
        halted = 1'b0;
    endtask

    // Runs one instruction from T0. sa/sb: not-ready cycles at the first
    // and second stall step (ignored when rnd=1, which randomises mem_ready/con).
    task automatic run_instr(input logic [31:0] instr, input bit c, input bit rnd,
                             input int sa, input int sb, input int limit,
                             output int cycles, output logic [26:0] last);
        int nstall = 0;
        int cnt    = 0;
        bit rdy, cc, was_stall;
        ir = instr;
        q.delete();
        push_instr(instr[31:27]);
        cycles = 0;
        while (q.size() > 0 && cycles < limit) begin
            was_stall = q[0].stall;
            if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
                cc  = 1'($urandom_range(0, 1));
            end else begin
                cc  = c;
                rdy = was_stall ? (cnt >= (nstall == 0 ? sa : sb)) : 1'b1;
            end
            do_cycle(rdy, cc, $sformatf("op%0d_cyc%0d", instr[31:27], cycles));
            cycles++;
            if (was_stall) begin
                if (rdy) begin nstall++; cnt = 0; end
                else cnt++;
            end
        end
        last = last_obs;
    endtask

    vec_t        vecs[18];
    int          cyc;
    logic [26:0] last;

    initial begin
        clear = 1'b0; con = 1'b0; mem_ready = 1'b0; ir = '0; dec_op = '0;
        halted = 1'b0; last_obs = '0;

        vecs[0]  = '{5'd3,  1'b0, 6, ZLO | GRA | RIN};
        vecs[1]  = '{5'd13, 1'b0, 6, ZLO | GRA | RIN};
        vecs[2]  = '{5'd17, 1'b0, 5, ZLO | GRA | RIN};
        vecs[3]  = '{5'd16, 1'b0, 7, ZHI | HIIN};
        vecs[4]  = '{5'd15, 1'b0, 7, ZHI | HIIN};
        vecs[5]  = '{5'd0,  1'b0, 8, MDROUT | GRA | RIN};
        vecs[6]  = '{5'd1,  1'b0, 6, ZLO | GRA | RIN};
        vecs[7]  = '{5'd2,  1'b0, 8, WRITE};
        vecs[8]  = '{5'd19, 1'b0, 7, ZLO};
        vecs[9]  = '{5'd19, 1'b1, 7, ZLO | PCIN};
        vecs[10] = '{5'd21, 1'b0, 4, GRA | ROUT | PCIN};
        vecs[11] = '{5'd20, 1'b0, 5, GRA | ROUT | PCIN};
        vecs[12] = '{5'd22, 1'b0, 4, INPORT | GRA | RIN};
        vecs[13] = '{5'd23, 1'b0, 4, GRA | ROUT | OUTPORT};
        vecs[14] = '{5'd24, 1'b0, 4, LOOUT | GRA | RIN};
        vecs[15] = '{5'd25, 1'b0, 4, HIOUT | GRA | RIN};
        vecs[16] = '{5'd26, 1'b0, 4, 27'd0};
        vecs[17] = '{5'd30, 1'b0, 4, 27'd0};

        for (int op = 0; op < 32; op++) begin
            dec_op = 5'(op);
            #1;
            check($sformatf("decode_op%0d", op), 64'(ref_cls), 64'(ref_class(5'(op))));
        end

        do_reset(2);

        for (int i = 0; i < 18; i++) begin
            run_instr({vecs[i].op, 27'($urandom)}, vecs[i].c, 1'b0, 0, 0, 100, cyc, last);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
            check($sformatf("vec%0d_last", i), 64'(last), 64'(vecs[i].last));
        end

        // Reset in the middle of an add's T5, then a clean add.
        run_instr(32'h18918000, 1'b0, 1'b0, 0, 0, 5, cyc, last);
        do_reset(1);
        run_instr(32'h18918000, 1'b0, 1'b0, 0, 0, 100, cyc, last);
        check("add_after_reset_cycles", 64'(cyc), 64'd6);

        // ld with memory stalls in T1 and T6.
        run_instr(32'h00000000, 1'b0, 1'b0, 3, 2, 100, cyc, last);
        check("ld_stall_cycles", 64'(cyc), 64'd13);

        // st with a write stall in T7.
        run_instr({5'd2, 27'd0}, 1'b0, 1'b0, 1, 3, 100, cyc, last);
        check("st_stall_cycles", 64'(cyc), 64'd12);

        // halt: idle with random inputs, then restart through clear.
        run_instr({5'd27, 27'd0}, 1'b0, 1'b0, 0, 0, 100, cyc, last);
        check("halt_cycles", 64'(cyc), 64'd4);
        for (int i = 0; i < 20; i++)
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "halted");
        do_reset(1);
        run_instr(32'h18918000, 1'b0, 1'b0, 0, 0, 100, cyc, last);
        check("restart_after_halt_cycles", 64'(cyc), 64'd6);

        // Random instruction stream with random handshakes and resets.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] instr;
            bit          cut;
            instr = {5'($urandom_range(0, 31)), 27'($urandom)};
            cut   = ($urandom_range(0, 15) == 0);
            run_instr(instr, 1'b0, 1'b1, 0, 0, cut ? $urandom_range(1, 6) : 400, cyc, last);
            if (!cut) check("rand_done", 64'(q.size()), 64'd0);
            if (halted) begin
                for (int i = 0; i < 3; i++) do_cycle(1'($urandom_range(0, 1)), 1'b0, "rand_halted");
            end
            if (cut || halted || q.size() > 0) do_reset($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
